// File: rtl/dual_wb_regfile.sv
// dual_wb_regfile
//   Register file and writeback consumer for the dual-issue core. Two
//   writeback buses (one per execute pipe) commit on the rising clock edge.
//   Same-address conflicts are resolved by issue order. Four combinational
//   read ports are provided, and a retired-writeback counter is maintained.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, each read port forwards a matching same-cycle effective
//   write. The younger write wins when both pipes match.
//   When undefined, reads see array contents only.
//
// Ports
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset (clears array and counter)
//   stop                 pipeline hold: no commit, no counting
//   num_a, num_b         1-bit issue-order tags of the pipe A / pipe B writeback
//   rfw_a, rfw_b         writeback buses {we, valid, addr, data}, we is the MSB
//   raddr_a1..raddr_b2   read addresses
//   rdata_a1..rdata_b2   read data (x0 always reads 0)
//   wb_count             count of committed valid writebacks (wraps)
module dual_wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stop,
    input  logic                       num_a,
    input  logic [2+ADDR_W+DATA_W-1:0] rfw_a,
    input  logic                       num_b,
    input  logic [2+ADDR_W+DATA_W-1:0] rfw_b,
    input  logic [ADDR_W-1:0]          raddr_a1,
    input  logic [ADDR_W-1:0]          raddr_a2,
    input  logic [ADDR_W-1:0]          raddr_b1,
    input  logic [ADDR_W-1:0]          raddr_b2,
    output logic [DATA_W-1:0]          rdata_a1,
    output logic [DATA_W-1:0]          rdata_a2,
    output logic [DATA_W-1:0]          rdata_b1,
    output logic [DATA_W-1:0]          rdata_b2,
    output logic [CNT_W-1:0]           wb_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    logic              we_a, vld_a, we_b, vld_b;
    logic [ADDR_W-1:0] waddr_a, waddr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;

    assign we_a    = rfw_a[2+ADDR_W+DATA_W-1];
    assign vld_a   = rfw_a[ADDR_W+DATA_W];
    assign waddr_a = rfw_a[DATA_W +: ADDR_W];
    assign wdata_a = rfw_a[DATA_W-1:0];

    assign we_b    = rfw_b[2+ADDR_W+DATA_W-1];
    assign vld_b   = rfw_b[ADDR_W+DATA_W];
    assign waddr_b = rfw_b[DATA_W +: ADDR_W];
    assign wdata_b = rfw_b[DATA_W-1:0];

    logic eff_a, eff_b, same_addr, b_wins, commit_a, commit_b;

    assign eff_a = we_a & vld_a & (waddr_a != '0) & ~stop;
    assign eff_b = we_b & vld_b & (waddr_b != '0) & ~stop;

    assign same_addr = eff_a & eff_b & (waddr_a == waddr_b);
    // A is younger only when it alone carries tag 1. Equal tags are
    // ambiguous, and B takes the conflict.
    assign b_wins    = ~(num_a & ~num_b);
    // Only the winner of a same-address conflict commits. The bypass path
    // reuses these qualifiers, so it needs no separate age compare.
    assign commit_a  = eff_a & ~(same_addr & b_wins);
    assign commit_b  = eff_b & ~(same_addr & ~b_wins);

    logic [1:0] vld_sum;
    assign vld_sum = {1'b0, vld_a} + {1'b0, vld_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            wb_count <= '0;
        end else begin
            if (commit_a) regs[waddr_a] <= wdata_a;
            if (commit_b) regs[waddr_b] <= wdata_b;
            // Valid non-writing instructions retire too, so count on valid.
            if (!stop) wb_count <= wb_count + CNT_W'(vld_sum);
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] val;
        if (ra == '0) begin
            val = '0;
`ifdef WB_BYPASS_EN
        end else if (commit_b && (waddr_b == ra)) begin
            val = wdata_b;
        end else if (commit_a && (waddr_a == ra)) begin
            val = wdata_a;
`endif
        end else begin
            val = regs[ra];
        end
        return val;
    endfunction

    assign rdata_a1 = read_port(raddr_a1);
    assign rdata_a2 = read_port(raddr_a2);
    assign rdata_b1 = read_port(raddr_b1);
    assign rdata_b2 = read_port(raddr_b2);

endmodule

// File: tb/tb_dual_wb_regfile.sv
// tb_dual_wb_regfile
//   Scoreboard bench for dual_wb_regfile. A reference model of the array and
//   the counter is updated on each commit edge. Expected read and count
//   values are pushed to a queue when a sample is requested, then popped and
//   compared against the DUT outputs. Compile with +define+WB_BYPASS_EN to
//   match a bypass-enabled design.
module tb_dual_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 64;
    localparam int BUS_W  = 2 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              stop = 1'b0;
    logic              num_a = 1'b0, num_b = 1'b0;
    logic [BUS_W-1:0]  rfw_a = '0, rfw_b = '0;
    logic [ADDR_W-1:0] raddr_a1 = '0, raddr_a2 = '0, raddr_b1 = '0, raddr_b2 = '0;
    logic [DATA_W-1:0] rdata_a1, rdata_a2, rdata_b1, rdata_b2;
    logic [CNT_W-1:0]  wb_count;

    dual_wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stop(stop),
        .num_a(num_a), .rfw_a(rfw_a), .num_b(num_b), .rfw_b(rfw_b),
        .raddr_a1(raddr_a1), .raddr_a2(raddr_a2),
        .raddr_b1(raddr_b1), .raddr_b2(raddr_b2),
        .rdata_a1(rdata_a1), .rdata_a2(rdata_a2),
        .rdata_b1(rdata_b1), .rdata_b2(rdata_b2),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl [32];
    logic [63:0] mdl_cnt;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] mk(input logic we, input logic v,
                                            input logic [4:0] a, input logic [31:0] d);
        return {we, v, a, d};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        mdl_cnt = '0;
    endtask

    // Apply one pipe's write to the model when it is a real write.
    task automatic model_write(input logic [BUS_W-1:0] bus);
        logic [4:0] a;
        a = bus[36:32];
        if (bus[38] && bus[37] && a != 5'd0) mdl[a] = bus[31:0];
    endtask

    // Commit in issue order: the older write first, the younger one over it.
    task automatic model_commit(input logic na, input logic [BUS_W-1:0] ba,
                                input logic nb, input logic [BUS_W-1:0] bb, input logic st);
        logic a_younger;
        if (st) return;
        mdl_cnt = mdl_cnt + 64'(ba[37]) + 64'(bb[37]);
        a_younger = (na != nb) ? na : 1'b0;
        if (a_younger) begin
            model_write(bb);
            model_write(ba);
        end else begin
            model_write(ba);
            model_write(bb);
        end
    endtask

    // Drive one writeback cycle, commit it, then drop the buses to idle.
    task automatic wb(input logic na, input logic [BUS_W-1:0] ba,
                      input logic nb, input logic [BUS_W-1:0] bb, input logic st);
        @(negedge clk);
        num_a = na; rfw_a = ba; num_b = nb; rfw_b = bb; stop = st;
        @(posedge clk);
        model_commit(na, ba, nb, bb, st);
        #1;
        rfw_a = '0; rfw_b = '0; num_a = 1'b0; num_b = 1'b0; stop = 1'b0;
    endtask

    // Read four consecutive registers starting at a, plus the counter.
    task automatic sample(input logic [4:0] a);
        logic [4:0]  ra [4];
        logic [63:0] obs [5];
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            ra[i] = a + 5'(i);
            sb_q.push_back('{$sformatf("rd_x%0d", ra[i]), 64'(mdl[ra[i]])});
        end
        sb_q.push_back('{"wb_count", mdl_cnt});
        raddr_a1 = ra[0]; raddr_a2 = ra[1]; raddr_b1 = ra[2]; raddr_b2 = ra[3];
        #1;
        obs[0] = 64'(rdata_a1); obs[1] = 64'(rdata_a2);
        obs[2] = 64'(rdata_b1); obs[3] = 64'(rdata_b2);
        obs[4] = wb_count;
        for (int i = 0; i < 5; i++) begin
            e = sb_q.pop_front();
            check(e.tag, obs[i], e.val);
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] old4;
        model_clear();

        // Reset from power-up, then read back every register.
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        for (int a = 0; a < 32; a += 4) sample(5'(a));

        // Dual commit to distinct registers.
        wb(1'b0, mk(1, 1, 5, 32'h11111111), 1'b0, mk(1, 1, 6, 32'h22222222), 1'b0);
        sample(5);

        // Same-address conflicts on x7.
        wb(1'b1, mk(1, 1, 7, 32'hAAAA0000), 1'b0, mk(1, 1, 7, 32'hBBBB0000), 1'b0);
        sample(7);
        wb(1'b0, mk(1, 1, 7, 32'hAAAA0000), 1'b0, mk(1, 1, 7, 32'hBBBB0000), 1'b0);
        sample(7);
        wb(1'b0, mk(1, 1, 7, 32'hCCCC0000), 1'b1, mk(1, 1, 7, 32'hDDDD0000), 1'b0);
        sample(7);
        wb(1'b1, mk(1, 1, 7, 32'hEEEE0000), 1'b1, mk(1, 1, 7, 32'hFFFF0000), 1'b0);
        sample(7);

        // x0 write is dropped but still counts.
        wb(1'b0, mk(1, 1, 0, 32'hDEADBEEF), 1'b0, '0, 1'b0);
        sample(0);

        // Bubble (valid low, we high) neither writes nor counts.
        wb(1'b0, mk(1, 1, 9, 32'h00000099), 1'b0, '0, 1'b0);
        wb(1'b0, '0, 1'b0, mk(1, 0, 9, 32'h5), 1'b0);
        sample(9);

        // Valid non-writing instruction counts only.
        wb(1'b0, mk(0, 1, 10, 32'h12345678), 1'b0, '0, 1'b0);
        sample(10);

        // Stop hold for three cycles, then release.
        wb(1'b0, mk(1, 1, 3, 32'h33333333), 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++)
            wb(1'b0, mk(1, 1, 3, 32'h0BAD0000 + 32'(i)), 1'b1, mk(1, 1, 3, 32'h0BAD1000), 1'b1);
        sample(3);
        wb(1'b0, mk(1, 1, 3, 32'h44444444), 1'b0, mk(1, 1, 2, 32'h55555555), 1'b0);
        sample(0);

        // Same-cycle read of a write in flight.
        @(negedge clk);
        old4 = mdl[4];
        rfw_a = mk(1, 1, 4, 32'h00001234);
        raddr_b1 = 5'd4;
        raddr_a1 = 5'd0;
`ifdef WB_BYPASS_EN
        sb_q.push_back('{"byp_same_cycle", 64'h1234});
`else
        sb_q.push_back('{"byp_same_cycle", 64'(old4)});
`endif
        sb_q.push_back('{"byp_x0", 64'h0});
        #1;
        e = sb_q.pop_front(); check(e.tag, 64'(rdata_b1), e.val);
        e = sb_q.pop_front(); check(e.tag, 64'(rdata_a1), e.val);
        @(posedge clk);
        model_commit(1'b0, rfw_a, 1'b0, '0, 1'b0);
        #1;
        rfw_a = '0;
        sample(4);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        sample(4);
        @(negedge clk) rst_n = 1'b1;
        #1;
        sample(5);

        if (sb_q.size() != 0) check("sb_q_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
